serial_add_ctrl: RTL and testbench

//  Bit-serial sequencer for the external 1-bit full-adder cell: latches two WIDTH-bit

---
 rtl/serial_add_ctrl.sv | 99 +++++++++
 tb/tb_serial_add_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: drives an external 1-bit full adder LSB-first,
// keeps the ripple carry in a flop and assembles the WIDTH-bit sum.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic           carry;
  logic [CW-1:0]  count;

  // Handshake: start is a level request sampled only in IDLE; once accepted,
  // start and operands are ignored until the add finishes. done pulses for one
  // cycle with sum/cout valid, and sum/cout then hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Sum bits arrive LSB-first, so they enter at the MSB and shift down.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          count <= count + CW'(1);
          if (count == LAST) begin
            cout  <= fa_cout;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Adder operands come only from flops, gated off outside RUN.
  assign fa_a   = (state == RUN) & a_sh[0];
  assign fa_b   = (state == RUN) & b_sh[0];
  assign fa_cin = (state == RUN) & carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural full adder on the fa_* port.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_s;
  logic             fa_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs[10];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_s    (fa_s),
    .fa_cout (fa_cout),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout)
  );

  // Clock and the external full-adder cell
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete add; entered and left at a falling edge with the DUT idle.
  task automatic do_add(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vcin);
    int n;
    logic [WIDTH:0] exp;
    a = va;
    b = vb;
    cin = vcin;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fa_first_bits", {29'd0, fa_a, fa_b, fa_cin}, {29'd0, va[0], vb[0], vcin});
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (done) break;
    end
    check("done_latency", n, WIDTH);
    check("busy_at_done", busy, 1'b1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("result", {cout, sum}, exp);
    tick();
    check("done_cleared", {busy, done}, 2'b00);
    check("result_held", {cout, sum}, exp);
  endtask

  initial begin
    int dcnt;
    int n_done;
    int last_done;
    int low_run;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_sum_cout", {cout, sum}, 9'd0);
    check("reset_busy_done", {busy, done}, 2'b00);
    check("reset_fa", {fa_a, fa_b, fa_cin}, 3'b000);

    // Table-driven adds
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].exp_cout, vecs[i].exp_sum});
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin);
    end

    // Start pulsed during RUN with different operands is ignored
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("busy_start_done_count", dcnt, 1);
    check("busy_start_sum", {cout, sum}, 9'h046);
    check("busy_start_idle", busy, 1'b0);

    // Reset mid-RUN aborts with no done
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_sum_cout", {cout, sum}, 9'd0);
    check("abort_fa", {fa_a, fa_b, fa_cin}, 3'b000);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    exp_q.push_back(9'h002);
    do_add(8'h01, 8'h01, 1'b0);

    // Continuous start: one add every WIDTH+2 cycles, one idle cycle between
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    n_done = 0;
    last_done = -1;
    low_run = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done) begin
        n_done++;
        check("stream_sum", {cout, sum}, 9'h030);
        if (last_done >= 0) check("stream_period", i - last_done, WIDTH + 2);
        last_done = i;
      end
      if (!busy) begin
        low_run++;
      end else if (low_run > 0) begin
        check("stream_idle_gap", low_run, 1);
        low_run = 0;
      end
    end
    check("stream_done_count", n_done, 4);
    start = 1'b0;
    dcnt = 0;
    while (busy && dcnt < 15) begin
      tick();
      dcnt++;
    end
    check("stream_drain", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
